ram_bank: RTL and testbench
===========================

Name: ram_bank

Overview:
- Parametrised single-port word RAM, successor to the SoC's simple test RAM.
- Adds a valid/ready request handshake, byte write strobes and a configurable read latency.
- Adds a hardware clear sequence after reset, with a status output.
- Sits between the core's load/store or fetch interface and backing storage; used in the testbench and in SoC top.

Parameters:
- AWIDTH, 8, word-address width; depth DEPTH = 2**AWIDTH words.
- DWIDTH, 32, data width in bits; multiple of 8, minimum 8.
- READ_LAT, 1, cycles from request accept to response; legal 1..4.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = skip the clear, contents undefined.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  bank can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address; word index = req_addr[AWIDTH+OFF_W-1:OFF_W], where OFF_W = log2(DWIDTH/8).
- req_be  in  DWIDTH/8  byte-lane write enables; ignored for reads.
- req_wdata  in  DWIDTH  write data.
- rsp_valid  out  1  response (read data or write ack) valid for exactly one cycle.
- rsp_rdata  out  DWIDTH  read data; 0 for write acks.
- rsp_err  out  1  address error; see Optional Feature.
- init_done  out  1  clear sequence complete, level.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0; FSM=CLEAR (or READY when CLEAR_ON_RESET=0); clear counter=0; latency pipeline emptied.
- FSM states:
  - CLEAR: writes 0 to word[cnt] each cycle, cnt increments; req_ready=0. After writing word DEPTH-1, moves to READY and sets init_done=1. Takes exactly DEPTH cycles after rst deasserts.
  - READY: req_ready=1 every cycle. No exit except rst.
- CLEAR_ON_RESET=0: FSM enters READY directly; req_ready=1 and init_done=1 on the first edge after rst deasserts.
- Accept = req_valid & req_ready, sampled at the rising edge.
- Write: at the accept edge, byte lane i of the addressed word is updated only where req_be[i]=1.
- Read: the array is sampled at the accept edge.
- Latency: rsp_valid is asserted READ_LAT cycles after the accept edge, for one cycle. Holds for reads and writes; a write ack carries rsp_rdata=0.
- Throughput: one accept per cycle; responses return strictly in order. No response backpressure; the consumer must always take the response.
- Read-after-write to the same word in consecutive cycles returns the new data; single port, so no same-cycle conflict.
- req_be=0 write: no array change, ack still issued.
- Address bits above AWIDTH+OFF_W-1 are ignored (aliasing) unless the optional feature is compiled in. Low OFF_W bits are ignored.
- rst asserted mid-operation: outputs return to reset values immediately (async); in-flight responses are discarded; CLEAR restarts from word 0.
- rsp_rdata returns to 0 whenever rsp_valid=0.

Optional Feature:
- Macro RAM_BANK_ADDR_CHK_EN.
- Defined: a request with any req_addr bit above AWIDTH+OFF_W-1 set is still accepted but does not modify the array. Its response carries rsp_err=1 and rsp_rdata=0 at the normal latency.
- Undefined: rsp_err is tied 0 and addresses alias.

Decomposition:
- Package ram_bank_pkg holds:
  - state enum {CLEAR, READY};
  - localparam helpers BE_W = DWIDTH/8 and OFF_W;
  - response struct {valid, we, err, data}.
- Sub-module ram_bank_rsp_pipe: READ_LAT-deep shift register of response structs.

Test Plan:
- Reset clear (AWIDTH=4): release rst -> req_ready=0 for 16 cycles, then init_done=1, req_ready=1; reads of words 0..15 all return 0.
- Byte strobes: write 0xAABBCCDD to 0x10 with be=0xF, then write 0x11223344 with be=0x5, then read 0x10 -> rsp_rdata=0xAA22CC44 one cycle after accept (READ_LAT=1).
- Latency/throughput (READ_LAT=3): back-to-back reads of 0x0,0x4,0x8 -> three consecutive rsp_valid pulses starting 3 cycles after the first accept, data in order.
- Read-after-write: write 0xDEADBEEF to 0x20 at cycle N, read 0x20 at cycle N+1 -> read returns 0xDEADBEEF.
- Reset mid-stream: assert rst while two reads are in flight -> rsp_valid drops the same cycle and no stale response appears; CLEAR restarts and previously written data reads back 0.
- RAM_BANK_ADDR_CHK_EN (AWIDTH=8): write to 0x400 -> ack with rsp_err=1; read 0x000 -> unchanged data with rsp_err=0. Without the macro, the same write lands at word 0.

Source files
------------

// File: rtl/ram_bank_pkg.sv
// Shared types and width helpers for the ram_bank word RAM.
// Optional address range checking is enabled with RAM_BANK_ADDR_CHK_EN.
package ram_bank_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Control half of a response; the top pairs it with a DWIDTH data field.
    typedef struct packed {
        logic valid;
        logic we;
        logic err;
    } rsp_ctl_t;

    function automatic int be_w(input int dwidth);
        return dwidth / 32'sd8;
    endfunction

    function automatic int off_w(input int dwidth);
        return $clog2(dwidth / 32'sd8);
    endfunction

endpackage

// File: rtl/ram_bank_rsp_pipe.sv
// Fixed-depth shift register that delays packed responses by LAT cycles.
// Async reset empties every stage so in-flight responses are dropped.
module ram_bank_rsp_pipe #(
    parameter int LAT = 1,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] rsp_in,
    output logic [W-1:0] rsp_out
);

    logic [W-1:0] stage_r [LAT];

    // Shift responses one stage per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                stage_r[i] <= {W{1'b0}};
            end
        end else begin
            stage_r[0] <= rsp_in;
            for (int i = 1; i < LAT; i++) begin
                stage_r[i] <= stage_r[i - 1];
            end
        end
    end

    assign rsp_out = stage_r[LAT - 1];

endmodule

// File: rtl/ram_bank.sv
// Single-port word RAM with valid/ready requests, byte strobes, fixed read
// latency and a post-reset clear. Define RAM_BANK_ADDR_CHK_EN to flag out-of-range addresses.
module ram_bank
    import ram_bank_pkg::*;
#(
    parameter int AWIDTH         = 8,
    parameter int DWIDTH         = 32,
    parameter int READ_LAT       = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [31:0]              req_addr,
    input  logic [(DWIDTH/8)-1:0]    req_be,
    input  logic [DWIDTH-1:0]        req_wdata,
    output logic                     rsp_valid,
    output logic [DWIDTH-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic                     init_done
);

    localparam int BYTE_W = 32'sd8;
    localparam int BE_W   = be_w(DWIDTH);
    localparam int OFF_W  = off_w(DWIDTH);
    localparam int DEPTH  = 2 ** AWIDTH;
    localparam int IDX_HI = AWIDTH + OFF_W - 32'sd1;
    localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(DEPTH - 32'sd1);
    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 32'sd0) ? CLEAR : READY;

    typedef struct packed {
        rsp_ctl_t          ctl;
        logic [DWIDTH-1:0] data;
    } rsp_t;

    localparam int RSP_W = $bits(rsp_t);

    logic [DWIDTH-1:0] mem_r [DEPTH];
    state_t            state_r;
    state_t            state_next_s;
    logic [AWIDTH-1:0] cnt_r;
    logic [AWIDTH-1:0] cnt_next_s;
    logic              ready_r;
    logic              done_r;
    logic              clear_we_s;
    logic              accept_s;
    logic              wr_en_s;
    logic              err_s;
    logic [AWIDTH-1:0] idx_s;
    logic              unused_addr_s;
    rsp_t              pipe_in_s;
    rsp_t              pipe_out_s;

    assign idx_s         = req_addr[IDX_HI:OFF_W];
    assign unused_addr_s = ^req_addr;
    assign accept_s      = req_valid & ready_r;
    assign wr_en_s       = accept_s & req_we & ~err_s;

`ifdef RAM_BANK_ADDR_CHK_EN
    assign err_s = |req_addr[31:IDX_HI + 32'sd1];
`else
    assign err_s = 1'b0;
`endif

    // Clear sequence walks every word once, then the bank stays ready until reset.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        clear_we_s   = 1'b0;
        case (state_r)
            CLEAR: begin
                clear_we_s = 1'b1;
                cnt_next_s = cnt_r + {{(AWIDTH-1){1'b0}}, 1'b1};
                if (cnt_r == LAST_IDX) begin
                    state_next_s = READY;
                end else begin
                    state_next_s = CLEAR;
                end
            end
            READY: begin
                state_next_s = READY;
            end
            default: begin
                state_next_s = RESET_STATE;
            end
        endcase
    end

    // State, clear counter and the registered handshake/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RESET_STATE;
            cnt_r   <= {AWIDTH{1'b0}};
            ready_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            ready_r <= (state_next_s == READY);
            done_r  <= (state_next_s == READY);
        end
    end

    // Storage array: clear writes take priority, requests update strobed lanes only.
    always_ff @(posedge clk) begin
        if (clear_we_s) begin
            mem_r[cnt_r] <= {DWIDTH{1'b0}};
        end else if (wr_en_s) begin
            for (int i = 0; i < BE_W; i++) begin
                if (req_be[i]) begin
                    mem_r[idx_s][BYTE_W*i +: BYTE_W] <= req_wdata[BYTE_W*i +: BYTE_W];
                end
            end
        end
    end

    // Response captured at the accept edge; only in-range reads carry data.
    always_comb begin
        pipe_in_s           = {RSP_W{1'b0}};
        pipe_in_s.ctl.valid = accept_s;
        pipe_in_s.ctl.we    = accept_s & req_we;
        pipe_in_s.ctl.err   = accept_s & err_s;
        if (accept_s && !req_we && !err_s) begin
            pipe_in_s.data = mem_r[idx_s];
        end else begin
            pipe_in_s.data = {DWIDTH{1'b0}};
        end
    end

    ram_bank_rsp_pipe #(
        .LAT (READ_LAT),
        .W   (RSP_W)
    ) u_rsp_pipe (
        .clk     (clk),
        .rst     (rst),
        .rsp_in  (pipe_in_s),
        .rsp_out (pipe_out_s)
    );

    assign req_ready = ready_r;
    assign init_done = done_r;
    assign rsp_valid = pipe_out_s.ctl.valid;
    assign rsp_err   = pipe_out_s.ctl.err;
    assign rsp_rdata = (pipe_out_s.ctl.valid && !pipe_out_s.ctl.we) ? pipe_out_s.data
                                                                     : {DWIDTH{1'b0}};

endmodule

// File: tb/tb_ram_bank.sv
// Scoreboard bench for ram_bank: a word-array reference model predicts every
// response at issue time; a monitor compares data, error flag and latency.
module tb_ram_bank;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int LAT   = 3;
    localparam int DEPTH = 16;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        init_done;

    ram_bank #(
        .AWIDTH(AW), .DWIDTH(DW), .READ_LAT(LAT), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .init_done(init_done)
    );

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [DEPTH];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic addr_err(input logic [31:0] a);
`ifdef RAM_BANK_ADDR_CHK_EN
        return a >= 32'(DEPTH * 4);
`else
        return 1'b0;
`endif
    endfunction

    // Drive one cycle of request inputs; predict the response if it will be accepted.
    task automatic issue(input logic v, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        exp_t e;
        int   idx;
        @(negedge clk);
        req_valid = v;
        req_we    = we;
        req_addr  = addr;
        req_be    = be;
        req_wdata = wd;
        if (v && req_ready === 1'b1) begin
            idx   = int'((addr / 32'd4) % 32'(DEPTH));
            e.err = addr_err(addr);
            e.due = cyc + LAT;
            if (we) begin
                if (!e.err) begin
                    for (int i = 0; i < 4; i++) begin
                        if (be[i]) model[idx][8*i +: 8] = wd[8*i +: 8];
                    end
                end
                e.data = 32'd0;
            end else begin
                e.data = e.err ? 32'd0 : model[idx];
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        issue(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (init_done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Monitor: every response must match the oldest prediction; idle cycles stay zero.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stray_rsp: actual=rsp_valid 1 required=no pending response (cycle %0d)", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, e.data);
                    check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    check("rsp_latency", 32'(cyc), 32'(e.due));
                end
            end else begin
                check("idle_valid", {31'd0, rsp_valid}, 32'd0);
                check("idle_rdata", rsp_rdata, 32'd0);
            end
        end
    end

    initial begin
        int n;
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = 32'd0; req_be = 4'd0; req_wdata = 32'd0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
        #1 rst = 1'b1;
        #2;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_init_done", {31'd0, init_done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            @(negedge clk);
            check("clear_req_ready", {31'd0, req_ready}, 32'(i == DEPTH));
            check("clear_init_done", {31'd0, init_done}, 32'(i == DEPTH));
        end

        // Every word reads back zero after the clear, back to back.
        for (int i = 0; i < DEPTH; i++) issue(1'b1, 1'b0, 32'(i * 4), 4'd0, 32'd0);
        idle();

        // Byte strobes, then read-after-write in consecutive cycles.
        issue(1'b1, 1'b1, 32'h10, 4'hF, 32'hAABBCCDD);
        issue(1'b1, 1'b1, 32'h10, 4'h5, 32'h11223344);
        issue(1'b1, 1'b0, 32'h10, 4'h0, 32'd0);
        idle();
        issue(1'b1, 1'b1, 32'h20, 4'hF, 32'hDEADBEEF);
        issue(1'b1, 1'b0, 32'h20, 4'h0, 32'd0);
        issue(1'b1, 1'b1, 32'h24, 4'h0, 32'hFFFFFFFF);
        issue(1'b1, 1'b0, 32'h24, 4'h0, 32'd0);
        idle();

        // Back-to-back reads through the latency pipeline.
        issue(1'b1, 1'b0, 32'h0, 4'h0, 32'd0);
        issue(1'b1, 1'b0, 32'h4, 4'h0, 32'd0);
        issue(1'b1, 1'b0, 32'h8, 4'h0, 32'd0);
        idle();

        // High address bits: error with the range check, alias onto word 0 without.
        issue(1'b1, 1'b1, 32'h400, 4'hF, 32'h5A5A5A5A);
        issue(1'b1, 1'b0, 32'h000, 4'h0, 32'd0);
        issue(1'b1, 1'b0, 32'h403, 4'h0, 32'd0);
        idle();
        drain();

        for (int k = 0; k < 400; k++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h3F);
            issue(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a,
                  4'($urandom), $urandom);
        end
        idle();
        drain();

        // Reset with one response visible and two more in flight.
        issue(1'b1, 1'b0, 32'h10, 4'h0, 32'd0);
        issue(1'b1, 1'b0, 32'h14, 4'h0, 32'd0);
        issue(1'b1, 1'b0, 32'h18, 4'h0, 32'd0);
        idle();
        #2 rst = 1'b1;
        #1;
        check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midrst_rsp_rdata", rsp_rdata, 32'd0);
        check("midrst_req_ready", {31'd0, req_ready}, 32'd0);
        check("midrst_init_done", {31'd0, init_done}, 32'd0);
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        wait_init(n);
        check("reclear_cycles", 32'(n), 32'(DEPTH));
        issue(1'b1, 1'b0, 32'h10, 4'h0, 32'd0);
        issue(1'b1, 1'b0, 32'h20, 4'h0, 32'd0);
        issue(1'b1, 1'b0, 32'h00, 4'h0, 32'd0);
        idle();
        drain();
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
